// File: rtl/nand_seq.sv
// Bit-serial logic unit that evaluates NAND/AND/OR/XOR/NOT one external NAND gate step per clock.
// Optional X/Z capture detection on nand_q is enabled by defining NAND_SEQ_XCHECK_EN.
module nand_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_err,
  output logic             nand_a,
  output logic             nand_b,
  input  logic             nand_q
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  logic [2:0]        op_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [WIDTH-1:0]  res_r;
  logic              t1_r;
  logic              t2_r;
  logic              t3_r;
  logic [1:0]        step_r;
  logic [IW-1:0]     bit_r;
  logic              err_r;
  logic              nand_a_r;
  logic              nand_b_r;
  logic              req_ready_r;
  logic              rsp_valid_r;

  logic              last_s;
  logic              last_bit_s;
  logic [1:0]        step_n_s;
  logic [WIDTH-1:0]  a_sh_s;
  logic [WIDTH-1:0]  b_sh_s;
  logic              a_cur_s;
  logic              b_cur_s;
  logic              t1_n_s;
  logic              t2_n_s;
  logic              t3_n_s;
  logic [1:0]        opnd_s;
  logic [1:0]        acc_opnd_s;

`ifdef NAND_SEQ_XCHECK_EN
  logic              xflag_r;
  logic              x_now_s;
`endif

  // Index of the final step of one bit; every op ends its bit by writing q.
  function automatic logic [1:0] last_step(input logic [2:0] op);
    case (op)
      3'b001:  last_step = 2'd1;
      3'b010:  last_step = 2'd2;
      3'b011:  last_step = 2'd3;
      default: last_step = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] step_opnds(input logic [2:0] op, input logic [1:0] step,
                                            input logic a, input logic b, input logic t1,
                                            input logic t2, input logic t3);
    case (op)
      3'b000: step_opnds = {a, b};
      3'b001: step_opnds = (step == 2'd0) ? {a, b} : {t1, t1};
      3'b010: begin
        case (step)
          2'd0:    step_opnds = {a, a};
          2'd1:    step_opnds = {b, b};
          default: step_opnds = {t1, t2};
        endcase
      end
      3'b011: begin
        case (step)
          2'd0:    step_opnds = {a, b};
          2'd1:    step_opnds = {a, t1};
          2'd2:    step_opnds = {b, t1};
          default: step_opnds = {t2, t3};
        endcase
      end
      3'b100:  step_opnds = {a, a};
      default: step_opnds = 2'b00;
    endcase
  endfunction

  // Next-step operands use the temp being captured this edge, so a step can consume its predecessor.
  always_comb begin
    last_s     = (step_r == last_step(op_r));
    last_bit_s = (bit_r == IW'(WIDTH - 1));
    a_sh_s     = a_r >> 1;
    b_sh_s     = b_r >> 1;
    t1_n_s     = t1_r;
    t2_n_s     = t2_r;
    t3_n_s     = t3_r;
    if (last_s) begin
      step_n_s = 2'd0;
      a_cur_s  = a_sh_s[0];
      b_cur_s  = b_sh_s[0];
    end else begin
      step_n_s = step_r + 2'd1;
      a_cur_s  = a_r[0];
      b_cur_s  = b_r[0];
      case (step_r)
        2'd0:    t1_n_s = nand_q;
        2'd1:    t2_n_s = nand_q;
        2'd2:    t3_n_s = nand_q;
        default: t3_n_s = t3_r;
      endcase
    end
    opnd_s     = step_opnds(op_r, step_n_s, a_cur_s, b_cur_s, t1_n_s, t2_n_s, t3_n_s);
    acc_opnd_s = step_opnds(req_op, 2'd0, req_a[0], req_b[0], 1'b0, 1'b0, 1'b0);
`ifdef NAND_SEQ_XCHECK_EN
    x_now_s    = $isunknown(nand_q);
`endif
  end

  // Sequencer: accepts a request, walks bits and steps through the gate, then holds the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_r        <= 3'b000;
      a_r         <= '0;
      b_r         <= '0;
      res_r       <= '0;
      t1_r        <= 1'b0;
      t2_r        <= 1'b0;
      t3_r        <= 1'b0;
      step_r      <= 2'd0;
      bit_r       <= '0;
      err_r       <= 1'b0;
      nand_a_r    <= 1'b0;
      nand_b_r    <= 1'b0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
`ifdef NAND_SEQ_XCHECK_EN
      xflag_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            op_r        <= req_op;
            a_r         <= req_a;
            b_r         <= req_b;
            res_r       <= '0;
            t1_r        <= 1'b0;
            t2_r        <= 1'b0;
            t3_r        <= 1'b0;
            step_r      <= 2'd0;
            bit_r       <= '0;
            req_ready_r <= 1'b0;
            state_r     <= STEP;
            if (req_op > 3'b100) begin
              err_r    <= 1'b1;
              nand_a_r <= 1'b0;
              nand_b_r <= 1'b0;
            end else begin
              err_r    <= 1'b0;
              nand_a_r <= acc_opnd_s[1];
              nand_b_r <= acc_opnd_s[0];
            end
          end else begin
            nand_a_r <= 1'b0;
            nand_b_r <= 1'b0;
          end
        end
        STEP: begin
          // A reserved op spends exactly one cycle here with the gate idle.
          if (err_r) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
          end else begin
            step_r <= step_n_s;
            t1_r   <= t1_n_s;
            t2_r   <= t2_n_s;
            t3_r   <= t3_n_s;
`ifdef NAND_SEQ_XCHECK_EN
            xflag_r <= xflag_r | x_now_s;
`endif
            if (last_s) begin
              res_r[bit_r] <= nand_q;
              if (last_bit_s) begin
                state_r     <= RESP;
                rsp_valid_r <= 1'b1;
                nand_a_r    <= 1'b0;
                nand_b_r    <= 1'b0;
`ifdef NAND_SEQ_XCHECK_EN
                err_r       <= xflag_r | x_now_s;
`else
                err_r       <= 1'b0;
`endif
              end else begin
                bit_r    <= bit_r + IW'(1);
                a_r      <= a_sh_s;
                b_r      <= b_sh_s;
                nand_a_r <= opnd_s[1];
                nand_b_r <= opnd_s[0];
              end
            end else begin
              nand_a_r <= opnd_s[1];
              nand_b_r <= opnd_s[0];
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            err_r       <= 1'b0;
`ifdef NAND_SEQ_XCHECK_EN
            xflag_r     <= 1'b0;
`endif
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          nand_a_r    <= 1'b0;
          nand_b_r    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_res   = res_r;
  assign rsp_err   = err_r;
  assign nand_a    = nand_a_r;
  assign nand_b    = nand_b_r;

endmodule
